// File: rtl/tracked_reg_bank_if.sv
// tracked_reg_bank_if: write/read/fill/error bus between a producer-consumer and the register bank
interface tracked_reg_bank_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_en;
  logic             rd_unwritten;
  logic             fill_start;
  logic             busy;
  logic [DEPTH-1:0] written_mask;
  logic             err;
  logic             err_clr;
  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_addr, fill_start, err_clr,
    input  rd_valid, rd_data, rd_en, rd_unwritten, busy, written_mask, err
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr, fill_start, err_clr,
    output rd_valid, rd_data, rd_en, rd_unwritten, busy, written_mask, err
  );
endinterface

// File: rtl/tracked_reg_bank.sv
// tracked_reg_bank: register bank with per-entry written flags, write-first reads and a fill engine
module tracked_reg_bank #(
  parameter int               WIDTH         = 4,
  parameter int               DEPTH         = 8,
  parameter bit               FILL_ON_RESET = 1'b0,
  parameter logic [WIDTH-1:0] FILL_VAL      = '0,
  parameter int               AW            = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst_n,
  tracked_reg_bank_if.slave bus
);
  typedef enum logic {IDLE, FILL} state_e;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  state_e           state_q;
  logic [AW-1:0]    ptr_q;
  logic             auto_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_unw_q;
  logic             err_q;
  logic             idle;
  logic             wr_ok;
  logic             rd_in;
  logic             fwd;
  logic             rd_hit;
  logic [WIDTH-1:0] rd_data_d;
  logic             new_err;
  assign idle      = state_q == IDLE;
  assign wr_ok     = idle & bus.wr_en & ({1'b0, bus.wr_addr} < DEPTH_W);
  assign rd_in     = {1'b0, bus.rd_addr} < DEPTH_W;
  assign fwd       = wr_ok & (bus.wr_addr == bus.rd_addr);
  assign rd_hit    = rd_in & (fwd | written_q[bus.rd_addr]);
  assign rd_data_d = fwd ? bus.wr_data : rd_hit ? mem_q[bus.rd_addr] : '0;
  assign new_err   = idle & ((bus.wr_en & ~wr_ok) | (bus.rd_req & ~rd_hit));
  // auto_q arms the post-reset fill for exactly the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      auto_q     <= FILL_ON_RESET;
      written_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_unw_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      auto_q     <= 1'b0;
      rd_valid_q <= idle & bus.rd_req;
      err_q      <= new_err | (err_q & ~bus.err_clr);
      if (idle & bus.rd_req) begin
        rd_data_q <= rd_data_d;
        rd_unw_q  <= ~rd_hit;
      end
      if (idle) begin
        if (bus.fill_start | auto_q) begin
          state_q <= FILL;
          ptr_q   <= '0;
        end
        if (wr_ok) written_q[bus.wr_addr] <= 1'b1;
      end else begin
        written_q[ptr_q] <= 1'b1;
        ptr_q            <= ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH-1)) state_q <= IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!idle) mem_q[ptr_q] <= FILL_VAL;
    else if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
  end
  assign bus.busy         = ~idle;
  assign bus.written_mask = written_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_en        = rd_data_q[0];
  assign bus.rd_unwritten = rd_unw_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_tracked_reg_bank.sv
// tb_tracked_reg_bank: random + directed checks of three bank configurations against a bench model
module tb_tracked_reg_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_c_n = 1'b0;
  logic chk_en = 1'b0;
  int   total = 0;
  int   passed = 0;
  always #5 clk = ~clk;

  tracked_reg_bank_if #(.WIDTH(4), .DEPTH(8)) ifa ();
  tracked_reg_bank_if #(.WIDTH(4), .DEPTH(6)) ifb ();
  tracked_reg_bank_if #(.WIDTH(4), .DEPTH(8)) ifc ();

  tracked_reg_bank #(.WIDTH(4), .DEPTH(8), .FILL_ON_RESET(1'b0), .FILL_VAL(4'h3))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  tracked_reg_bank #(.WIDTH(4), .DEPTH(6), .FILL_ON_RESET(1'b0), .FILL_VAL(4'hC))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  tracked_reg_bank #(.WIDTH(4), .DEPTH(8), .FILL_ON_RESET(1'b1), .FILL_VAL(4'h3))
    dut_c (.clk(clk), .rst_n(rst_c_n), .bus(ifc));

  logic [3:0] m_mem [8];
  logic [7:0] m_wr;
  int         m_pos;
  logic       m_rv, m_un, m_err;
  logic [3:0] m_data;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic model_reset();
    m_wr = '0; m_pos = -1; m_rv = 0; m_un = 0; m_err = 0; m_data = '0;
  endtask

  // Reference for dut_a: m_pos is the next entry to fill, -1 when not filling
  task automatic model_update();
    logic ne;
    ne = 1'b0;
    if (m_pos >= 0) begin
      m_mem[m_pos] = 4'h3;
      m_wr[m_pos] = 1'b1;
      m_rv = 1'b0;
      m_pos = (m_pos == 7) ? -1 : m_pos + 1;
    end else begin
      m_rv = ifa.rd_req;
      if (ifa.rd_req) begin
        if (ifa.wr_en && ifa.wr_addr == ifa.rd_addr) begin m_data = ifa.wr_data; m_un = 0; end
        else if (m_wr[ifa.rd_addr]) begin m_data = m_mem[ifa.rd_addr]; m_un = 0; end
        else begin m_data = 4'h0; m_un = 1; ne = 1'b1; end
      end
      if (ifa.wr_en) begin m_mem[ifa.wr_addr] = ifa.wr_data; m_wr[ifa.wr_addr] = 1'b1; end
      if (ifa.fill_start) m_pos = 0;
    end
    m_err = ne | (m_err & !ifa.err_clr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_rd_valid", ifa.rd_valid, m_rv);
      chk("a_rd_data", ifa.rd_data, m_data);
      chk("a_rd_en", ifa.rd_en, m_data[0]);
      chk("a_rd_unwritten", ifa.rd_unwritten, m_un);
      chk("a_busy", ifa.busy, m_pos >= 0);
      chk("a_written_mask", ifa.written_mask, m_wr);
      chk("a_err", ifa.err, m_err);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] b45;
    b45 = 8'h45;
    {ifa.wr_en, ifa.wr_addr, ifa.wr_data, ifa.rd_req, ifa.rd_addr, ifa.fill_start, ifa.err_clr} = '0;
    {ifb.wr_en, ifb.wr_addr, ifb.wr_data, ifb.rd_req, ifb.rd_addr, ifb.fill_start, ifb.err_clr} = '0;
    {ifc.wr_en, ifc.wr_addr, ifc.wr_data, ifc.rd_req, ifc.rd_addr, ifc.fill_start, ifc.err_clr} = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", ifa.rd_valid, 0);
    chk("rst_rd_data", ifa.rd_data, 0);
    chk("rst_rd_unwritten", ifa.rd_unwritten, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_mask", ifa.written_mask, 0);
    chk("rst_err", ifa.err, 0);
    chk("rst_c_busy", ifc.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    // unwritten read flags error, then clear
    ifa.rd_req = 1; ifa.rd_addr = 3; step(); ifa.rd_req = 0;
    chk("unw_rd_valid", ifa.rd_valid, 1);
    chk("unw_rd_data", ifa.rd_data, 0);
    chk("unw_flag", ifa.rd_unwritten, 1);
    chk("unw_err", ifa.err, 1);
    ifa.err_clr = 1; step(); ifa.err_clr = 0;
    chk("err_cleared", ifa.err, 0);
    // write then read
    ifa.wr_en = 1; ifa.wr_addr = 2; ifa.wr_data = b45[3:0]; step(); ifa.wr_en = 0;
    ifa.rd_req = 1; ifa.rd_addr = 2; step(); ifa.rd_req = 0;
    chk("wr_rd_data", ifa.rd_data, 4'h5);
    chk("wr_rd_en", ifa.rd_en, 1);
    chk("wr_rd_unw", ifa.rd_unwritten, 0);
    chk("wr_mask", ifa.written_mask, 8'b0000_0100);
    // same-cycle write-first
    ifa.wr_en = 1; ifa.wr_addr = 6; ifa.wr_data = 4'hA; ifa.rd_req = 1; ifa.rd_addr = 6;
    step(); ifa.wr_en = 0; ifa.rd_req = 0;
    chk("fwd_data", ifa.rd_data, 4'hA);
    chk("fwd_en", ifa.rd_en, 0);
    chk("fwd_unw", ifa.rd_unwritten, 0);
    // fill with traffic that must be ignored
    ifa.fill_start = 1; step(); ifa.fill_start = 0;
    n = 1;
    while (ifa.busy && n < 20) begin
      ifa.wr_en = 1'($urandom); ifa.wr_addr = 3'($urandom); ifa.wr_data = 4'($urandom);
      ifa.rd_req = 1'($urandom); ifa.rd_addr = 3'($urandom); ifa.fill_start = 1'($urandom);
      step();
      if (ifa.busy) n++;
    end
    {ifa.wr_en, ifa.rd_req, ifa.fill_start} = '0;
    chk("fill_busy_cycles", n, 8);
    chk("fill_mask", ifa.written_mask, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      ifa.rd_req = 1; ifa.rd_addr = 3'(i); step();
      chk("fill_rd_data", ifa.rd_data, 4'h3);
    end
    ifa.rd_req = 0;
    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      ifa.wr_en = ($urandom_range(2) == 0); ifa.wr_addr = 3'($urandom); ifa.wr_data = 4'($urandom);
      ifa.rd_req = ($urandom_range(1) == 0); ifa.rd_addr = 3'($urandom);
      ifa.err_clr = ($urandom_range(7) == 0); ifa.fill_start = ($urandom_range(39) == 0);
      step();
    end
    {ifa.wr_en, ifa.rd_req, ifa.err_clr, ifa.fill_start} = '0;
    // DEPTH=6: out-of-range accesses
    chk("b_err_init", ifb.err, 0);
    ifb.wr_en = 1; ifb.wr_addr = 7; ifb.wr_data = 4'h9; step(); ifb.wr_en = 0;
    chk("b_oor_wr_err", ifb.err, 1);
    chk("b_oor_wr_mask", ifb.written_mask, 0);
    ifb.err_clr = 1; step(); ifb.err_clr = 0;
    chk("b_err_clr", ifb.err, 0);
    ifb.rd_req = 1; ifb.rd_addr = 7; step(); ifb.rd_req = 0;
    chk("b_oor_rd_valid", ifb.rd_valid, 1);
    chk("b_oor_rd_data", ifb.rd_data, 0);
    chk("b_oor_rd_unw", ifb.rd_unwritten, 1);
    chk("b_oor_rd_err", ifb.err, 1);
    ifb.err_clr = 1; ifb.rd_req = 1; ifb.rd_addr = 6; step(); ifb.err_clr = 0; ifb.rd_req = 0;
    chk("b_err_clr_loses", ifb.err, 1);
    ifb.wr_en = 1; ifb.wr_addr = 5; ifb.wr_data = 4'h6; step(); ifb.wr_en = 0;
    ifb.rd_req = 1; ifb.rd_addr = 5; step(); ifb.rd_req = 0;
    chk("b_rd5_data", ifb.rd_data, 4'h6);
    chk("b_rd5_unw", ifb.rd_unwritten, 0);
    chk("b_mask", ifb.written_mask, 6'b100000);
    ifb.fill_start = 1; step(); ifb.fill_start = 0;
    n = 1;
    while (ifb.busy && n < 20) begin step(); if (ifb.busy) n++; end
    chk("b_fill_cycles", n, 6);
    chk("b_fill_mask", ifb.written_mask, 6'h3F);
    ifb.rd_req = 1; ifb.rd_addr = 0; step(); ifb.rd_req = 0;
    chk("b_fill_data", ifb.rd_data, 4'hC);
    chk("b_fill_en", ifb.rd_en, 0);
    // FILL_ON_RESET with reset mid-fill
    @(negedge clk); rst_c_n = 1'b1;
    step();
    chk("c_auto_busy", ifc.busy, 1);
    repeat (3) step();
    chk("c_partial_mask", ifc.written_mask, 8'b0000_0111);
    rst_c_n = 1'b0; #1;
    chk("c_rst_busy", ifc.busy, 0);
    chk("c_rst_mask", ifc.written_mask, 0);
    @(negedge clk); rst_c_n = 1'b1;
    step();
    n = 1;
    while (ifc.busy && n < 20) begin step(); if (ifc.busy) n++; end
    chk("c_refill_cycles", n, 8);
    chk("c_refill_mask", ifc.written_mask, 8'hFF);
    ifc.rd_req = 1; ifc.rd_addr = 5; step(); ifc.rd_req = 0;
    chk("c_rd_valid", ifc.rd_valid, 1);
    chk("c_rd_data", ifc.rd_data, 4'h3);
    rst_c_n = 1'b0; #1;
    chk("c_rst_rd_valid", ifc.rd_valid, 0);
    chk("c_rst_rd_data", ifc.rd_data, 0);
    chk_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
